// File: rtl/simple_pic_pkg.sv
// Shared constants and types for the simple 8-input programmable interrupt controller.
package simple_pic_pkg;

  localparam logic [7:0]  PIC_EOI_CODE  = 8'h20;
  localparam logic [15:0] PIC_PORT_BASE = 16'h0020;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2
  } pic_state_e;

  // Decoded register write for one acked bus cycle.
  typedef struct packed {
    logic       eoi;
    logic       imr_wr;
    logic [7:0] imr_val;
  } pic_bus_cmd_t;

endpackage

// File: rtl/pic_prio_enc.sv
// Lowest-index priority encoder: index of the lowest set request bit.
module pic_prio_enc #(
  parameter  int W  = 8,
  localparam int IW = $clog2(W)
) (
  input  logic [W-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] index
);

  always_comb begin
    valid = |req;
    index = '0;
    // Scan downward so the lowest set bit is the last assignment.
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i]) index = IW'(i);
    end
  end

endmodule

// File: rtl/simple_pic.sv
// Simple PIC: edge-latched IRR, IMR mask, ISR nesting, INTA-style handshake and
// a 16-bit Wishbone register port at 0x20/0x21.
module simple_pic
  import simple_pic_pkg::*;
#(
  parameter logic [7:0] VEC_BASE = 8'h08,
  parameter logic [7:0] IMR_RST  = 8'hFC
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic        wb_adr_i,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  input  logic [7:0]  irq_i,
  output logic [7:0]  irq_ack_o,
  output logic        wb_tgc_o,
  input  logic        wb_tgc_i,
  output logic [7:0]  vec_o
);

  logic [7:0]   irq_q, irr, isr, imr;
  logic         armed, tgc_q;
  pic_state_e   state;
  logic         isr_vld, cand_vld;
  logic [2:0]   isr_idx, cand_idx;
  logic [7:0]   isr_allow, cand_req, edges, ack_set, eoi_clr;
  logic         acc, at_base, tgc_rise, tgc_fall;
  pic_bus_cmd_t cmd;

  pic_prio_enc #(.W(8)) u_isr_enc (.req(isr), .valid(isr_vld), .index(isr_idx));

  // Only sources strictly above the highest-priority in-service level may interrupt.
  assign isr_allow = isr_vld ? ((8'd1 << isr_idx) - 8'd1) : 8'hFF;
  assign cand_req  = irr & ~imr & isr_allow;

  pic_prio_enc #(.W(8)) u_cand_enc (.req(cand_req), .valid(cand_vld), .index(cand_idx));

  assign acc         = wb_stb_i & wb_cyc_i & ~wb_ack_o;
  assign at_base     = (wb_adr_i == PIC_PORT_BASE[1]);
  assign cmd.eoi     = acc & wb_we_i & at_base & wb_sel_i[0] & (wb_dat_i[7:0] == PIC_EOI_CODE);
  assign cmd.imr_wr  = acc & wb_we_i & at_base & wb_sel_i[1];
  assign cmd.imr_val = wb_dat_i[15:8];

  assign tgc_rise = wb_tgc_i & ~tgc_q;
  assign tgc_fall = ~wb_tgc_i & tgc_q;
  // armed blanks the first cycle after reset so levels held through reset are not edges.
  assign edges    = irq_i & ~irq_q & {8{armed}};
  assign ack_set  = ((state == ST_REQ) && tgc_rise && cand_vld) ? (8'd1 << cand_idx) : 8'd0;
  assign eoi_clr  = (cmd.eoi && isr_vld) ? (8'd1 << isr_idx) : 8'd0;

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      irq_q    <= '0;
      armed    <= 1'b0;
      tgc_q    <= 1'b0;
      irr      <= '0;
      isr      <= '0;
      imr      <= IMR_RST;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      irq_q    <= irq_i;
      armed    <= 1'b1;
      tgc_q    <= wb_tgc_i;
      irr      <= (irr & ~ack_set) | edges;
      isr      <= (isr & ~eoi_clr) | ack_set;
      if (cmd.imr_wr) imr <= cmd.imr_val;
      wb_ack_o <= wb_stb_i & wb_cyc_i & ~wb_ack_o;
      wb_dat_o <= (acc && !wb_we_i && at_base) ? {imr, irr} : 16'h0000;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state     <= ST_IDLE;
      wb_tgc_o  <= 1'b0;
      vec_o     <= '0;
      irq_ack_o <= '0;
    end else begin
      irq_ack_o <= '0;
      case (state)
        ST_IDLE: begin
          if (cand_vld) begin
            state    <= ST_REQ;
            wb_tgc_o <= 1'b1;
          end
        end
        ST_REQ: begin
          if (tgc_rise) begin
            state     <= ST_ACK;
            wb_tgc_o  <= 1'b0;
            vec_o     <= VEC_BASE + (cand_vld ? {5'd0, cand_idx} : 8'd7);
            irq_ack_o <= ack_set;
          end else if (!cand_vld) begin
            state    <= ST_IDLE;
            wb_tgc_o <= 1'b0;
          end
        end
        ST_ACK: begin
          if (tgc_fall) state <= ST_IDLE;
        end
        default: begin
          state    <= ST_IDLE;
          wb_tgc_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simple_pic.sv
// Directed self-checking bench for simple_pic; drives and samples on the falling edge.
module tb_simple_pic;

  logic        wb_clk_i, wb_rst_i;
  logic [15:0] wb_dat_i, wb_dat_o;
  logic        wb_adr_i, wb_we_i, wb_stb_i, wb_cyc_i, wb_ack_o;
  logic [1:0]  wb_sel_i;
  logic [7:0]  irq_i, irq_ack_o, vec_o;
  logic        wb_tgc_o, wb_tgc_i;

  int n_chk = 0;
  int n_err = 0;

  simple_pic dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i),
    .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o), .irq_i(irq_i), .irq_ack_o(irq_ack_o),
    .wb_tgc_o(wb_tgc_o), .wb_tgc_i(wb_tgc_i), .vec_o(vec_o)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  task automatic nclk(input int n);
    repeat (n) @(negedge wb_clk_i);
  endtask

  task automatic do_reset();
    wb_rst_i = 1'b0; irq_i = '0; wb_tgc_i = 1'b0;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0; wb_adr_i = 1'b0; wb_sel_i = '0; wb_dat_i = '0;
    nclk(2);
    wb_rst_i = 1'b1;
    nclk(2);
  endtask

  task automatic bus_wr(input logic adr, input logic [1:0] sel, input logic [15:0] d,
                        output logic a1, output logic a2);
    wb_adr_i = adr; wb_sel_i = sel; wb_dat_i = d; wb_we_i = 1'b1; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    nclk(1); a1 = wb_ack_o;
    nclk(1); a2 = wb_ack_o;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic bus_rd(input logic adr, output logic [15:0] d, output logic a1);
    logic a2;
    wb_adr_i = adr; wb_sel_i = 2'b11; wb_we_i = 1'b0; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    nclk(1); a1 = wb_ack_o; d = wb_dat_o;
    nclk(1); a2 = wb_ack_o;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
  endtask

  task automatic handshake(output logic [7:0] v, output logic [7:0] ak);
    wb_tgc_i = 1'b1;
    nclk(1); v = vec_o; ak = irq_ack_o;
    wb_tgc_i = 1'b0;
    nclk(1);
  endtask

  // Pulse one IRQ line; on return the PIC is in REQ if that source is deliverable.
  task automatic pulse_irq(input int n);
    irq_i[n] = 1'b1; nclk(1);
    irq_i[n] = 1'b0; nclk(1);
  endtask

  task automatic test_reset();
    logic [15:0] d; logic a;
    wb_rst_i = 1'b0; irq_i = '0; wb_tgc_i = 1'b0;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0; wb_adr_i = 1'b0; wb_sel_i = '0; wb_dat_i = '0;
    nclk(2);
    n_chk++; if ({wb_tgc_o, vec_o, irq_ack_o, wb_ack_o, wb_dat_o} !== 34'd0) begin n_err++;
      $display("FAIL reset_outputs: got tgc=%b vec=%h ack=%h wback=%b dat=%h exp all 0", wb_tgc_o, vec_o, irq_ack_o, wb_ack_o, wb_dat_o); end
    wb_rst_i = 1'b1; nclk(2);
    bus_rd(1'b0, d, a);
    n_chk++; if (d !== 16'hFC00) begin n_err++; $display("FAIL reset_regs: got %h exp FC00", d); end
  endtask

  task automatic test_keyboard();
    logic [7:0] v, ak;
    do_reset();
    irq_i[1] = 1'b1; nclk(1);
    n_chk++; if (wb_tgc_o !== 1'b0) begin n_err++; $display("FAIL kbd_tgc_early: got %b exp 0", wb_tgc_o); end
    irq_i[1] = 1'b0; nclk(1);
    n_chk++; if (wb_tgc_o !== 1'b1) begin n_err++; $display("FAIL kbd_tgc: got %b exp 1", wb_tgc_o); end
    wb_tgc_i = 1'b1; nclk(1);
    n_chk++; if (vec_o !== 8'h09) begin n_err++; $display("FAIL kbd_vec: got %h exp 09", vec_o); end
    n_chk++; if (irq_ack_o !== 8'h02) begin n_err++; $display("FAIL kbd_ack: got %h exp 02", irq_ack_o); end
    n_chk++; if (dut.isr !== 8'h02) begin n_err++; $display("FAIL kbd_isr: got %h exp 02", dut.isr); end
    n_chk++; if (wb_tgc_o !== 1'b0) begin n_err++; $display("FAIL kbd_tgc_drop: got %b exp 0", wb_tgc_o); end
    nclk(1);
    n_chk++; if (irq_ack_o !== 8'h00) begin n_err++; $display("FAIL kbd_ack_pulse: got %h exp 00", irq_ack_o); end
    wb_tgc_i = 1'b0; nclk(1);
    v = vec_o; ak = irq_ack_o;
  endtask

  task automatic test_priority();
    logic [7:0] v, ak; logic a1, a2;
    do_reset();
    pulse_irq(1);
    handshake(v, ak);
    bus_wr(1'b0, 2'b10, 16'h0000, a1, a2);
    irq_i = 8'h09; nclk(1);
    irq_i = 8'h00; nclk(1);
    n_chk++; if (wb_tgc_o !== 1'b1) begin n_err++; $display("FAIL prio_tgc: got %b exp 1", wb_tgc_o); end
    handshake(v, ak);
    n_chk++; if (v !== 8'h08) begin n_err++; $display("FAIL prio_vec: got %h exp 08", v); end
    n_chk++; if (ak !== 8'h01) begin n_err++; $display("FAIL prio_ack: got %h exp 01", ak); end
    n_chk++; if (dut.isr !== 8'h03) begin n_err++; $display("FAIL prio_isr: got %h exp 03", dut.isr); end
    nclk(3);
    n_chk++; if (wb_tgc_o !== 1'b0) begin n_err++; $display("FAIL prio_block0: got %b exp 0", wb_tgc_o); end
    bus_wr(1'b0, 2'b01, 16'h0020, a1, a2);
    nclk(2);
    n_chk++; if (wb_tgc_o !== 1'b0) begin n_err++; $display("FAIL prio_block1: got %b exp 0", wb_tgc_o); end
    bus_wr(1'b0, 2'b01, 16'h0020, a1, a2);
    n_chk++; if (wb_tgc_o !== 1'b1) begin n_err++; $display("FAIL prio_unblock: got %b exp 1", wb_tgc_o); end
    handshake(v, ak);
    n_chk++; if ({v, ak} !== 16'h0B08) begin n_err++; $display("FAIL prio_irq3: got vec=%h ack=%h exp 0B/08", v, ak); end
  endtask

  task automatic test_mask();
    logic [7:0] v, ak; logic [15:0] d; logic a1, a2;
    do_reset();
    bus_wr(1'b0, 2'b10, 16'hFF00, a1, a2);
    pulse_irq(2);
    nclk(3);
    n_chk++; if (wb_tgc_o !== 1'b0) begin n_err++; $display("FAIL mask_tgc: got %b exp 0", wb_tgc_o); end
    bus_rd(1'b0, d, a1);
    n_chk++; if (d !== 16'hFF04) begin n_err++; $display("FAIL mask_irr_kept: got %h exp FF04", d); end
    bus_wr(1'b0, 2'b10, 16'hFB00, a1, a2);
    n_chk++; if (wb_tgc_o !== 1'b1) begin n_err++; $display("FAIL unmask_tgc: got %b exp 1", wb_tgc_o); end
    handshake(v, ak);
    n_chk++; if (v !== 8'h0A) begin n_err++; $display("FAIL unmask_vec: got %h exp 0A", v); end
  endtask

  task automatic test_withdraw();
    logic a1, a2;
    do_reset();
    pulse_irq(0);
    n_chk++; if (wb_tgc_o !== 1'b1) begin n_err++; $display("FAIL wd_req: got %b exp 1", wb_tgc_o); end
    bus_wr(1'b0, 2'b10, 16'h0100, a1, a2);
    n_chk++; if (wb_tgc_o !== 1'b0) begin n_err++; $display("FAIL wd_drop: got %b exp 0", wb_tgc_o); end
  endtask

  task automatic test_spurious();
    logic [15:0] d; logic a;
    do_reset();
    pulse_irq(0);
    wb_adr_i = 1'b0; wb_sel_i = 2'b10; wb_dat_i = 16'hFD00; wb_we_i = 1'b1; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    nclk(1);
    n_chk++; if (wb_ack_o !== 1'b1) begin n_err++; $display("FAIL spur_wback: got %b exp 1", wb_ack_o); end
    wb_tgc_i = 1'b1;
    nclk(1);
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    n_chk++; if (vec_o !== 8'h0F) begin n_err++; $display("FAIL spur_vec: got %h exp 0F", vec_o); end
    n_chk++; if (irq_ack_o !== 8'h00) begin n_err++; $display("FAIL spur_ack: got %h exp 00", irq_ack_o); end
    n_chk++; if (dut.isr !== 8'h00) begin n_err++; $display("FAIL spur_isr: got %h exp 00", dut.isr); end
    wb_tgc_i = 1'b0; nclk(1);
    bus_rd(1'b0, d, a);
    n_chk++; if (d !== 16'hFD01) begin n_err++; $display("FAIL spur_irr: got %h exp FD01", d); end
  endtask

  task automatic test_bus();
    logic [7:0] v, ak; logic [15:0] d; logic a1, a2;
    do_reset();
    pulse_irq(1);
    handshake(v, ak);
    n_chk++; if (wb_ack_o !== 1'b0) begin n_err++; $display("FAIL bus_ack_idle: got %b exp 0", wb_ack_o); end
    bus_wr(1'b0, 2'b11, 16'h5A20, a1, a2);
    n_chk++; if ({a1, a2} !== 2'b10) begin n_err++; $display("FAIL bus_ack_shape: got %b%b exp 10", a1, a2); end
    n_chk++; if (dut.isr !== 8'h00) begin n_err++; $display("FAIL bus_eoi: got %h exp 00", dut.isr); end
    pulse_irq(4);
    bus_rd(1'b0, d, a1);
    n_chk++; if (d !== 16'h5A10) begin n_err++; $display("FAIL bus_read: got %h exp 5A10", d); end
    bus_wr(1'b1, 2'b11, 16'hFF20, a1, a2);
    bus_rd(1'b1, d, a1);
    n_chk++; if (d !== 16'h0000) begin n_err++; $display("FAIL bus_adr1_read: got %h exp 0000", d); end
    bus_rd(1'b0, d, a1);
    n_chk++; if (d !== 16'h5A10) begin n_err++; $display("FAIL bus_adr1_wr_ignored: got %h exp 5A10", d); end
    bus_wr(1'b0, 2'b11, 16'h0033, a1, a2);
    bus_rd(1'b0, d, a1);
    n_chk++; if (d !== 16'h0010) begin n_err++; $display("FAIL bus_non_eoi: got %h exp 0010", d); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d; logic a1, a2;
    do_reset();
    pulse_irq(1);
    irq_i[1] = 1'b1; wb_tgc_i = 1'b1; nclk(1);
    n_chk++; if ({vec_o, irq_ack_o} !== 16'h0902) begin n_err++; $display("FAIL b2b_ack: got vec=%h ack=%h exp 09/02", vec_o, irq_ack_o); end
    irq_i[1] = 1'b0; wb_tgc_i = 1'b0; nclk(1);
    bus_rd(1'b0, d, a1);
    n_chk++; if (d !== 16'hFC02) begin n_err++; $display("FAIL b2b_set_wins: got %h exp FC02", d); end
    pulse_irq(0);
    n_chk++; if (wb_tgc_o !== 1'b1) begin n_err++; $display("FAIL b2b_nest_req: got %b exp 1", wb_tgc_o); end
    wb_tgc_i = 1'b1;
    bus_wr(1'b0, 2'b01, 16'h0020, a1, a2);
    n_chk++; if (dut.isr !== 8'h01) begin n_err++; $display("FAIL b2b_eoi_ack: got %h exp 01", dut.isr); end
    n_chk++; if (vec_o !== 8'h08) begin n_err++; $display("FAIL b2b_eoi_vec: got %h exp 08", vec_o); end
    wb_tgc_i = 1'b0; nclk(1);
  endtask

  task automatic test_reset_mid_ack();
    logic [15:0] d; logic a;
    do_reset();
    irq_i[1] = 1'b1; nclk(2);
    wb_tgc_i = 1'b1; nclk(1);
    n_chk++; if (vec_o !== 8'h09) begin n_err++; $display("FAIL rst_pre_vec: got %h exp 09", vec_o); end
    wb_rst_i = 1'b0; nclk(1);
    n_chk++; if ({wb_tgc_o, vec_o, irq_ack_o, wb_ack_o, wb_dat_o} !== 34'd0) begin n_err++;
      $display("FAIL rst_mid_outputs: got tgc=%b vec=%h ack=%h wback=%b dat=%h exp all 0", wb_tgc_o, vec_o, irq_ack_o, wb_ack_o, wb_dat_o); end
    wb_rst_i = 1'b1; nclk(5);
    n_chk++; if (wb_tgc_o !== 1'b0) begin n_err++; $display("FAIL rst_held_level: got %b exp 0", wb_tgc_o); end
    bus_rd(1'b0, d, a);
    n_chk++; if (d !== 16'hFC00) begin n_err++; $display("FAIL rst_mid_regs: got %h exp FC00", d); end
    wb_tgc_i = 1'b0; irq_i[1] = 1'b0; nclk(1);
    pulse_irq(1);
    n_chk++; if (wb_tgc_o !== 1'b1) begin n_err++; $display("FAIL rst_rearm: got %b exp 1", wb_tgc_o); end
  endtask

  initial begin
    wb_rst_i = 1'b1; irq_i = '0; wb_tgc_i = 1'b0;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0; wb_adr_i = 1'b0; wb_sel_i = '0; wb_dat_i = '0;
    #2;
    test_reset();
    test_keyboard();
    test_priority();
    test_mask();
    test_withdraw();
    test_spurious();
    test_bus();
    test_back_to_back();
    test_reset_mid_ack();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/simple_pic.md
SIMPLE_PIC -- requirements
Module: simple_pic

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter VEC_BASE, default 8'h08, is the vector base; IRQn SHALL map to vector VEC_BASE+n.
REQ-003 Parameter IMR_RST, default 8'hFC, is the reset mask (IRQ0 and IRQ1 enabled).
REQ-004 Ports SHALL be exactly:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  asynchronous reset, active-low
- wb_dat_i  in  16  write data
- wb_dat_o  out  16  read data
- wb_adr_i  in  1  address bit 1 of the I/O port (0 selects ports 0x20/0x21)
- wb_sel_i  in  2  byte lanes: [0]=port 0x20, [1]=port 0x21
- wb_we_i  in  1  write enable
- wb_stb_i, wb_cyc_i  in  1 each  strobe and cycle
- wb_ack_o  out  1  acknowledge
- irq_i  in  8  interrupt request levels from peripherals
- irq_ack_o  out  8  per-source one-cycle acknowledge pulse
- wb_tgc_o  out  1  interrupt request to the CPU
- wb_tgc_i  in  1  interrupt acknowledge from the CPU
- vec_o  out  8  vector, valid while wb_tgc_i is high

Function
REQ-005 The register irq_q SHALL sample irq_i every cycle; a rising edge (irq_i & ~irq_q) on bit n SHALL set IRR[n].
REQ-006 The candidate SHALL be the lowest n with IRR[n]=1 and IMR[n]=0, and with n less than the index of the lowest set ISR bit (ISR=0 allows all n).
REQ-007 The FSM SHALL have three states:
- IDLE: go to REQ when a candidate exists.
- REQ: wb_tgc_o=1; on a rising edge of wb_tgc_i go to ACK; if the candidate vanishes before that, return to IDLE with wb_tgc_o=0 in the next cycle.
- ACK: wb_tgc_o=0; hold vec_o; return to IDLE on a falling edge of wb_tgc_i.
REQ-008 On the rising edge of wb_tgc_i, within the same clock and with a candidate n, the block SHALL:
- clear IRR[n] and set ISR[n];
- pulse irq_ack_o[n] for exactly one cycle;
- register vec_o = VEC_BASE+n, valid from the next cycle.
REQ-009 A rising edge of wb_tgc_i with no candidate (spurious) SHALL give vec_o = VEC_BASE+7, with no IRR/ISR change and no irq_ack_o pulse.
REQ-010 Writing 8'h20 on lane 0 at adr 0 (EOI) SHALL clear the lowest set ISR bit; other lane-0 values SHALL be ignored.
REQ-011 A write on lane 1 at adr 0 SHALL load IMR <= wb_dat_i[15:8].
REQ-012 A read at adr 0 SHALL return {IMR, IRR}; any access with adr 1 SHALL read 16'h0000 and ignore writes.
REQ-013 wb_ack_o SHALL rise one cycle after stb&cyc and stay high for one cycle per access; register updates SHALL occur on the acked cycle.
REQ-014 If IRR[n] is cleared by acknowledge in the same cycle as a new edge on n, IRR[n] SHALL end at 1 (set wins).
REQ-015 An EOI in the same cycle as an acknowledge SHALL clear based on the pre-update ISR, then apply the acknowledge set.
REQ-016 Masking a bit SHALL NOT clear IRR or ISR; unmasking SHALL allow a latched IRR bit to raise wb_tgc_o.

Reset
REQ-017 While wb_rst_i=0, the block SHALL hold IRR=0, ISR=0, irq_q=0, IMR=IMR_RST, FSM=IDLE, wb_tgc_o=0, vec_o=0, irq_ack_o=0, wb_ack_o=0, wb_dat_o=0.
REQ-018 Reset asserted mid-handshake SHALL abandon the cycle; after release, still-high irq_i levels SHALL NOT produce edges until they fall and rise again.

Structure
REQ-019 The shared defines include SHALL hold the EOI code (8'h20), the port base (0x20), and the FSM state encodings.
REQ-020 The 8-bit lowest-index priority encoder SHALL be a sub-module pic_prio_enc (outputs: valid, 3-bit index); it SHALL be instanced for candidate selection and for EOI bit selection.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Keyboard path: after reset, pulse irq_i[1] and raise wb_tgc_i -> wb_tgc_o high 2 cycles after the edge; vec_o=8'h09; irq_ack_o=8'h02 for one cycle; ISR=8'h02.
- Priority: IRQ1 in service, edges on irq_i[0] and irq_i[3] with IMR=0 -> IRQ0 is served (vec 8'h08); IRQ3 is blocked until two EOIs.
- Mask: IMR=8'hFF, edge on irq_i[2] -> no wb_tgc_o; after write IMR=8'hFB -> wb_tgc_o asserts; vec_o=8'h0A.
- Spurious: mask IRQ0 while in REQ, with wb_tgc_i rising the same cycle -> vec_o=8'h0F; no ack pulse; ISR unchanged.
- Bus: write 16'h5A20 with sel=2'b11 -> EOI applied and IMR=8'h5A; read returns {8'h5A, IRR}; wb_ack_o is one cycle, one cycle after stb.
- Reset mid-ACK: with wb_tgc_i high, pulse wb_rst_i low -> all outputs 0 and IMR=8'hFC; a held-high irq_i raises no request.
